// File: rtl/sdram_pkg.sv
// Shared SDR SDRAM definitions used by both the controller and the device-side responder.
// Contents: command encodings ({nRAS,nCAS,nWE}), mode-register field positions,
// burst-length / CAS-latency encodings, protocol-violation codes, and the burst FSM state type.
package sdram_pkg;

  typedef enum logic [2:0] {
    CmdLmr   = 3'b000,
    CmdRef   = 3'b001,
    CmdPre   = 3'b010,
    CmdAct   = 3'b011,
    CmdWrite = 3'b100,
    CmdRead  = 3'b101,
    CmdBst   = 3'b110,
    CmdNop   = 3'b111
  } sdram_cmd_e;

  // Mode register field positions
  localparam int unsigned ModeBlLsb = 0;
  localparam int unsigned ModeClLsb = 4;
  localparam int unsigned ModeWbBit = 9;
  localparam int unsigned PreAllBit = 10;

  // Burst-length and CAS-latency encodings
  localparam logic [2:0] Bl1    = 3'b000;
  localparam logic [2:0] Bl2    = 3'b001;
  localparam logic [2:0] Bl4    = 3'b010;
  localparam logic [2:0] Bl8    = 3'b011;
  localparam logic [2:0] BlFull = 3'b111;
  localparam logic [2:0] Cl2    = 3'd2;
  localparam logic [2:0] Cl3    = 3'd3;

  typedef enum logic [2:0] {
    ErrNone       = 3'd0,
    ErrActOpen    = 3'd1,
    ErrBankClosed = 3'd2,
    ErrBankBusy   = 3'd3,
    ErrNoMode     = 3'd4,
    ErrBadCl      = 3'd5,
    ErrTrcd       = 3'd6
  } sdram_err_e;

  typedef enum logic [1:0] {
    StIdle,
    StWrBurst,
    StRdBurst
  } burst_st_e;

  // Word count for the non-full-page encodings; reserved encodings behave as length 1.
  function automatic logic [3:0] burst_len(input logic [2:0] bl);
    logic [3:0] len;
    case (bl)
      Bl1:     len = 4'd1;
      Bl2:     len = 4'd2;
      Bl4:     len = 4'd4;
      Bl8:     len = 4'd8;
      default: len = 4'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/sdram_rd_pipe.sv
// CAS-latency delay line for read data.
// Ports: clk, rst (sync, active-high), cl3 (1: CL=3, 0: CL=2), in_valid/in_data (word
// fetched on the READ edge), out_valid/out_data (registered, CL edges after the fetch).
module sdram_rd_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        cl3,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        out_valid,
  output logic [15:0] out_data
);

  logic [1:0]  v_q;
  logic [15:0] d0_q;
  logic [15:0] d1_q;

  // Stage 0 captures on the fetch edge; the output register is one (CL2) or two (CL3)
  // stages further on, so the output register itself is the last of CL stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q       <= '0;
      d0_q      <= '0;
      d1_q      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      v_q       <= {v_q[0], in_valid};
      d0_q      <= in_data;
      d1_q      <= d0_q;
      out_valid <= cl3 ? v_q[1] : v_q[0];
      out_data  <= cl3 ? d1_q : d0_q;
    end
  end

endmodule

// File: rtl/sdram_responder.sv
// SDR SDRAM device-side responder: decodes the command bus, holds the mode register,
// tracks open banks and tRCD, runs write/read bursts against an inferred byte-enabled RAM,
// and reports protocol violations.
// Ports: clk, rst (sync, active-high); command bus CKE/nCS/nRAS/nCAS/nWE, A, BA;
// DQML/DQMH write masks; dq_in write data; dq_out/dq_oe registered read data;
// mode_reg, bank_open, refresh_cnt status; cmd_err pulse and held err_code.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int unsigned MEM_AW = 11,
  parameter int unsigned TRCD   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CKE,
  input  logic        nCS,
  input  logic        nRAS,
  input  logic        nCAS,
  input  logic        nWE,
  input  logic [12:0] A,
  input  logic [1:0]  BA,
  input  logic        DQML,
  input  logic        DQMH,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic [12:0] mode_reg,
  output logic [3:0]  bank_open,
  output logic [15:0] refresh_cnt,
  output logic        cmd_err,
  output logic [2:0]  err_code
);

  localparam int unsigned RcdW = (TRCD > 1) ? $clog2(TRCD) : 1;

  logic        cmd_valid;
  sdram_cmd_e  cmd;

  burst_st_e   st_q, st_d;
  logic [1:0]  bank_q, bank_d;
  logic [8:0]  col_q, col_d;
  logic [3:0]  rem_q, rem_d;
  logic        full_q, full_d;
  logic [12:0] mode_q, mode_d;
  logic        mode_ok_q, mode_ok_d;
  logic [3:0]  open_q, open_d;
  logic [3:0][RcdW-1:0] rcd_q, rcd_d;
  logic [15:0] ref_q, ref_d;
  logic        err_q, err_d;
  sdram_err_e  code_q, code_d;

  logic              mem_we;
  logic              rd_push;
  logic [MEM_AW-1:0] mem_addr;
  logic [15:0]       rd_data;
  logic [3:0]        start_len;
  logic              start_full;
  logic [15:0]       mem [2**MEM_AW];

  assign cmd_valid = CKE & ~nCS;
  assign cmd       = sdram_cmd_e'({nRAS, nCAS, nWE});

  always_comb begin
    st_d       = st_q;
    bank_d     = bank_q;
    col_d      = col_q;
    rem_d      = rem_q;
    full_d     = full_q;
    mode_d     = mode_q;
    mode_ok_d  = mode_ok_q;
    open_d     = open_q;
    ref_d      = ref_q;
    err_d      = 1'b0;
    code_d     = code_q;
    mem_we     = 1'b0;
    rd_push    = 1'b0;
    mem_addr   = MEM_AW'({bank_q, col_q});
    start_len  = 4'd1;
    start_full = 1'b0;
    for (int b = 0; b < 4; b++) begin
      rcd_d[b] = (rcd_q[b] != '0) ? rcd_q[b] - RcdW'(1) : rcd_q[b];
    end

    // Burst continuation; a command below may override it.
    unique case (st_q)
      StWrBurst, StRdBurst: begin
        mem_we  = (st_q == StWrBurst);
        rd_push = (st_q == StRdBurst);
        col_d   = col_q + 9'd1;
        if (!full_q) begin
          rem_d = rem_q - 4'd1;
          if (rem_q == 4'd1) st_d = StIdle;
        end
      end
      default: ;
    endcase

    if (cmd_valid) begin
      unique case (cmd)
        CmdAct: begin
          if (open_q[BA]) begin
            err_d  = 1'b1;
            code_d = ErrActOpen;
          end else begin
            open_d[BA] = 1'b1;
            rcd_d[BA]  = RcdW'(TRCD - 1);
          end
        end
        CmdRead, CmdWrite: begin
          if (!mode_ok_q) begin
            err_d  = 1'b1;
            code_d = ErrNoMode;
          end else if (!open_q[BA]) begin
            err_d  = 1'b1;
            code_d = ErrBankClosed;
          end else if (rcd_q[BA] != '0) begin
            err_d  = 1'b1;
            code_d = ErrTrcd;
          end else begin
            // Word 0 is transferred on this edge; the FSM carries on from the next column.
            start_full = (mode_q[ModeBlLsb +: 3] == BlFull);
            start_len  = burst_len(mode_q[ModeBlLsb +: 3]);
            if (cmd == CmdWrite && mode_q[ModeWbBit]) begin
              start_full = 1'b0;
              start_len  = 4'd1;
            end
            mem_addr = MEM_AW'({BA, A[8:0]});
            mem_we   = (cmd == CmdWrite);
            rd_push  = (cmd == CmdRead);
            bank_d   = BA;
            col_d    = A[8:0] + 9'd1;
            full_d   = start_full;
            rem_d    = start_len - 4'd1;
            if (start_full || start_len != 4'd1) begin
              st_d = (cmd == CmdWrite) ? StWrBurst : StRdBurst;
            end else begin
              st_d = StIdle;
            end
          end
        end
        CmdBst: begin
          st_d    = StIdle;
          mem_we  = 1'b0;
          rd_push = 1'b0;
        end
        CmdPre: begin
          if (A[PreAllBit]) open_d = '0;
          else open_d[BA] = 1'b0;
          if (st_q != StIdle && (A[PreAllBit] || BA == bank_q)) begin
            st_d    = StIdle;
            mem_we  = 1'b0;
            rd_push = 1'b0;
          end
        end
        CmdRef: begin
          if (open_q != '0) begin
            err_d  = 1'b1;
            code_d = ErrBankBusy;
          end else begin
            ref_d = ref_q + 16'd1;
          end
        end
        CmdLmr: begin
          if (open_q != '0) begin
            err_d  = 1'b1;
            code_d = ErrBankBusy;
          end else if (A[ModeClLsb +: 3] != Cl2 && A[ModeClLsb +: 3] != Cl3) begin
            err_d  = 1'b1;
            code_d = ErrBadCl;
          end else begin
            mode_d    = A;
            mode_ok_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= StIdle;
      bank_q    <= '0;
      col_q     <= '0;
      rem_q     <= '0;
      full_q    <= 1'b0;
      mode_q    <= '0;
      mode_ok_q <= 1'b0;
      open_q    <= '0;
      rcd_q     <= '0;
      ref_q     <= '0;
      err_q     <= 1'b0;
      code_q    <= ErrNone;
    end else begin
      st_q      <= st_d;
      bank_q    <= bank_d;
      col_q     <= col_d;
      rem_q     <= rem_d;
      full_q    <= full_d;
      mode_q    <= mode_d;
      mode_ok_q <= mode_ok_d;
      open_q    <= open_d;
      rcd_q     <= rcd_d;
      ref_q     <= ref_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  // Storage is not cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      if (!DQML) mem[mem_addr][7:0]  <= dq_in[7:0];
      if (!DQMH) mem[mem_addr][15:8] <= dq_in[15:8];
    end
  end

  assign rd_data = mem[mem_addr];

  sdram_rd_pipe u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .cl3       (mode_q[ModeClLsb +: 3] == Cl3),
    .in_valid  (rd_push),
    .in_data   (rd_data),
    .out_valid (dq_oe),
    .out_data  (dq_out)
  );

  assign mode_reg    = mode_q;
  assign bank_open   = open_q;
  assign refresh_cnt = ref_q;
  assign cmd_err     = err_q;
  assign err_code    = code_q;

endmodule

// File: tb/tb_sdram_responder.sv
module tb_sdram_responder;
  import sdram_pkg::*;

  logic        clk;
  logic        rst;
  logic        CKE, nCS, nRAS, nCAS, nWE;
  logic [12:0] A;
  logic [1:0]  BA;
  logic        DQML, DQMH;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic [12:0] mode_reg;
  logic [3:0]  bank_open;
  logic [15:0] refresh_cnt;
  logic        cmd_err;
  logic [2:0]  err_code;

  int checks = 0;
  int errors = 0;

  sdram_responder dut (
    .clk         (clk),
    .rst         (rst),
    .CKE         (CKE),
    .nCS         (nCS),
    .nRAS        (nRAS),
    .nCAS        (nCAS),
    .nWE         (nWE),
    .A           (A),
    .BA          (BA),
    .DQML        (DQML),
    .DQMH        (DQMH),
    .dq_in       (dq_in),
    .dq_out      (dq_out),
    .dq_oe       (dq_oe),
    .mode_reg    (mode_reg),
    .bank_open   (bank_open),
    .refresh_cnt (refresh_cnt),
    .cmd_err     (cmd_err),
    .err_code    (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a);
    {nRAS, nCAS, nWE} = c;
    BA = b;
    A  = a;
  endtask

  // Advance past one rising edge; outputs of that edge are then stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a);
    drive(c, b, a);
    tick();
    drive(CmdNop, 2'd0, 13'd0);
  endtask

  initial begin
    rst = 1'b1; CKE = 1'b1; nCS = 1'b0; DQML = 1'b0; DQMH = 1'b0; dq_in = '0;
    drive(CmdNop, 2'd0, 13'd0);
    tick();
    tick();
    rst = 1'b0;
    check("rst_dq_out", 32'(dq_out), 0);
    check("rst_dq_oe", 32'(dq_oe), 0);
    check("rst_mode_reg", 32'(mode_reg), 0);
    check("rst_bank_open", 32'(bank_open), 0);
    check("rst_refresh_cnt", 32'(refresh_cnt), 0);
    check("rst_cmd_err", 32'(cmd_err), 0);
    check("rst_err_code", 32'(err_code), 0);

    // READ before any LMR
    cmd(CmdRead, 2'd0, 13'd0);
    check("err4_pulse", 32'(cmd_err), 1);
    check("err4_code", 32'(err_code), 4);
    tick();
    check("err4_pulse_end", 32'(cmd_err), 0);
    check("err4_code_held", 32'(err_code), 4);
    check("err4_no_read", 32'(dq_oe), 0);

    // Init: PRECHARGE all, 2x AUTO_REFRESH, LMR CL2 full page
    cmd(CmdPre, 2'd0, 13'h400);
    cmd(CmdRef, 2'd0, 13'd0);
    cmd(CmdRef, 2'd0, 13'd0);
    cmd(CmdLmr, 2'd0, 13'h027);
    check("init_mode_reg", 32'(mode_reg), 'h027);
    check("init_refresh_cnt", 32'(refresh_cnt), 2);
    check("init_cmd_err", 32'(cmd_err), 0);

    // Full-page write 0..511 to bank1, terminated by BST whose data must not land
    cmd(CmdAct, 2'd1, 13'd5);
    check("act_bank_open", 32'(bank_open), 'b0010);
    tick();
    drive(CmdWrite, 2'd1, 13'd0);
    dq_in = 16'd0;
    tick();
    drive(CmdNop, 2'd0, 13'd0);
    for (int k = 1; k < 512; k++) begin
      dq_in = 16'(k);
      tick();
    end
    drive(CmdBst, 2'd0, 13'd0);
    dq_in = 16'hDEAD;
    tick();
    drive(CmdNop, 2'd0, 13'd0);
    check("wr_no_err", 32'(cmd_err), 0);

    // Full-page read back with CL2, BST so that word 511 is last
    cmd(CmdRead, 2'd1, 13'd0);
    check("fp_rd_latency", 32'(dq_oe), 0);
    for (int k = 0; k < 512; k++) begin
      if (k == 511) drive(CmdBst, 2'd0, 13'd0);
      tick();
      drive(CmdNop, 2'd0, 13'd0);
      check("fp_rd_word", {15'd0, dq_oe, dq_out}, 32'h10000 | k);
    end
    tick();
    check("fp_rd_oe_drop", 32'(dq_oe), 0);

    // BL4 CL3 read wrapping at column 511
    cmd(CmdPre, 2'd0, 13'h400);
    cmd(CmdLmr, 2'd0, 13'h032);
    check("bl4_mode_reg", 32'(mode_reg), 'h032);
    cmd(CmdAct, 2'd1, 13'd9);
    tick();
    cmd(CmdRead, 2'd1, 13'h1FE);
    tick();
    check("bl4_latency", 32'(dq_oe), 0);
    tick();
    check("bl4_w0", {15'd0, dq_oe, dq_out}, 32'h101FE);
    tick();
    check("bl4_w1", {15'd0, dq_oe, dq_out}, 32'h101FF);
    tick();
    check("bl4_w2", {15'd0, dq_oe, dq_out}, 32'h10000);
    tick();
    check("bl4_w3", {15'd0, dq_oe, dq_out}, 32'h10001);
    tick();
    check("bl4_oe_drop", 32'(dq_oe), 0);

    // Byte mask: single-location writes, CL2 BL1
    cmd(CmdPre, 2'd0, 13'h400);
    cmd(CmdLmr, 2'd0, 13'h220);
    cmd(CmdAct, 2'd2, 13'd1);
    tick();
    dq_in = 16'hFFFF;
    cmd(CmdWrite, 2'd2, 13'd7);
    dq_in = 16'hA5C3;
    DQMH  = 1'b1;
    cmd(CmdWrite, 2'd2, 13'd7);
    DQMH  = 1'b0;
    dq_in = 16'h0000;
    cmd(CmdRead, 2'd2, 13'd7);
    tick();
    check("dqm_word", {15'd0, dq_oe, dq_out}, 32'h1FFC3);
    tick();
    check("dqm_oe_drop", 32'(dq_oe), 0);

    // ACTIVE on an already open bank
    cmd(CmdAct, 2'd2, 13'd3);
    check("err1_code", {28'd0, cmd_err, err_code}, 'h9);
    check("err1_bank_open", 32'(bank_open), 'b0100);

    // WRITE one cycle after ACTIVE
    cmd(CmdAct, 2'd3, 13'd0);
    cmd(CmdWrite, 2'd3, 13'd0);
    check("err6_code", {28'd0, cmd_err, err_code}, 'hE);

    // AUTO_REFRESH with banks open
    cmd(CmdRef, 2'd0, 13'd0);
    check("err3_code", {28'd0, cmd_err, err_code}, 'hB);
    check("err3_refresh_cnt", 32'(refresh_cnt), 2);

    // LMR with CL=1
    cmd(CmdPre, 2'd0, 13'h400);
    cmd(CmdLmr, 2'd0, 13'h010);
    check("err5_code", {28'd0, cmd_err, err_code}, 'hD);
    check("err5_mode_kept", 32'(mode_reg), 'h220);

    // Deselected command is ignored
    nCS = 1'b1;
    cmd(CmdAct, 2'd0, 13'd0);
    nCS = 1'b0;
    check("ncs_ignored", 32'(bank_open), 0);

    // Reset in the middle of a full-page read burst
    cmd(CmdLmr, 2'd0, 13'h027);
    cmd(CmdAct, 2'd1, 13'd0);
    tick();
    cmd(CmdRead, 2'd1, 13'd0);
    tick();
    check("mid_w0", {15'd0, dq_oe, dq_out}, 32'h10000);
    tick();
    check("mid_w1", {15'd0, dq_oe, dq_out}, 32'h10001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_oe", 32'(dq_oe), 0);
    check("mid_rst_bank_open", 32'(bank_open), 0);
    check("mid_rst_refresh_cnt", 32'(refresh_cnt), 0);
    tick();
    check("mid_rst_stays_idle", 32'(dq_oe), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
